bram_stream_writer: RTL and testbench

BRAM_STREAM_WRITER -- requirements
Module: bram_stream_writer

---
 rtl/intan_bram_pkg.sv | 16 +
 rtl/sat_counter32.sv | 29 ++
 rtl/bram_stream_writer.sv | 175 +++++++++++++++++
 tb/tb_bram_stream_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intan_bram_pkg.sv
// Shared defaults and state encoding for the BRAM ping-pong stream writer.
package intan_bram_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16384;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL_0 = 3'd1,
    ST_FILL_1 = 3'd2,
    ST_WAIT_0 = 3'd3,
    ST_WAIT_1 = 3'd4
  } wr_state_e;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  logic [31:0] count_r;

  // Count register: clear has priority, increment stops at the ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (clr) begin
      count_r <= 32'd0;
    end else if (inc && (count_r != SAT_MAX)) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/bram_stream_writer.sv
// Streams upstream sample words into a BRAM split into two halves that the
// host drains alternately; a half is locked until the host acknowledges it.
module bram_stream_writer
  import intan_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic [1:0]            half_ack,
  output logic [1:0]            half_full,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [31:0]           words_written,
  output logic [31:0]           stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_0 = PTR_W'(DEPTH / 2 - 1);
  localparam logic [PTR_W-1:0] LAST_1 = PTR_W'(DEPTH - 1);

  wr_state_e             state_r, state_s;
  logic [PTR_W-1:0]      word_ptr_r, word_ptr_s;
  logic [1:0]            half_full_r, half_full_s;
  logic [1:0]            set_s;
  logic [31:0]           words_written_r, words_written_s;
  logic                  start_s;
  logic                  ready_s;
  logic                  transfer_s;
  logic                  stall_inc_s;
  logic                  bram_en_r;
  logic [3:0]            bram_we_r;
  logic [ADDR_WIDTH-1:0] bram_addr_r;
  logic [DATA_WIDTH-1:0] bram_din_r;

  // Handshake qualifiers; dropping enable withdraws ready within the same cycle.
  always_comb begin
    ready_s     = enable && ((state_r == ST_FILL_0) || (state_r == ST_FILL_1));
    transfer_s  = s_valid && ready_s;
    stall_inc_s = enable && s_valid && !ready_s && (state_r != ST_IDLE);
  end

  // Next-state, pointer, half-full flags and word count.
  always_comb begin
    state_s         = state_r;
    start_s         = 1'b0;
    set_s           = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s = ST_FILL_0;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL_0: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (transfer_s && (word_ptr_r == LAST_0)) begin
          set_s[0] = 1'b1;
          state_s  = half_full_r[1] ? ST_WAIT_1 : ST_FILL_1;
        end else begin
          state_s = ST_FILL_0;
        end
      end
      ST_FILL_1: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (transfer_s && (word_ptr_r == LAST_1)) begin
          set_s[1] = 1'b1;
          state_s  = half_full_r[0] ? ST_WAIT_0 : ST_FILL_0;
        end else begin
          state_s = ST_FILL_1;
        end
      end
      ST_WAIT_0: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (!half_full_r[0]) begin
          state_s = ST_FILL_0;
        end else begin
          state_s = ST_WAIT_0;
        end
      end
      ST_WAIT_1: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (!half_full_r[1]) begin
          state_s = ST_FILL_1;
        end else begin
          state_s = ST_WAIT_1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A half completing on the same edge as its ack stays full.
    if (start_s) begin
      word_ptr_s      = '0;
      half_full_s     = 2'b00;
      words_written_s = 32'd0;
    end else if (transfer_s) begin
      word_ptr_s      = word_ptr_r + PTR_W'(1);
      half_full_s     = (half_full_r & ~half_ack) | set_s;
      words_written_s = words_written_r + 32'd1;
    end else begin
      word_ptr_s      = word_ptr_r;
      half_full_s     = half_full_r & ~half_ack;
      words_written_s = words_written_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      word_ptr_r      <= '0;
      half_full_r     <= 2'b00;
      words_written_r <= 32'd0;
    end else begin
      state_r         <= state_s;
      word_ptr_r      <= word_ptr_s;
      half_full_r     <= half_full_s;
      words_written_r <= words_written_s;
    end
  end

  // BRAM write port: one-cycle strobe per accepted word, address/data held between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en_r   <= 1'b0;
      bram_we_r   <= 4'h0;
      bram_addr_r <= '0;
      bram_din_r  <= '0;
    end else if (transfer_s) begin
      bram_en_r   <= 1'b1;
      bram_we_r   <= 4'hF;
      bram_addr_r <= ADDR_WIDTH'({word_ptr_r, 2'b00});
      bram_din_r  <= s_data;
    end else begin
      bram_en_r   <= 1'b0;
      bram_we_r   <= 4'h0;
      bram_addr_r <= bram_addr_r;
      bram_din_r  <= bram_din_r;
    end
  end

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_s),
    .inc   (stall_inc_s),
    .count (stall_cycles)
  );

  assign s_ready       = ready_s;
  assign half_full     = half_full_r;
  assign bram_en       = bram_en_r;
  assign bram_we       = bram_we_r;
  assign bram_addr     = bram_addr_r;
  assign bram_din      = bram_din_r;
  assign words_written = words_written_r;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer (DEPTH=16): a transaction-level model
// is compared every cycle, plus hand-computed checkpoints along the way.
module tb_bram_stream_writer;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int HALF  = DEPTH / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [1:0]    half_ack = 2'b00;
  logic [1:0]    half_full;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [31:0]   words_written;
  logic [31:0]   stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  bram_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .half_ack      (half_ack),
    .half_full     (half_full),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .words_written (words_written),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: capture session running, which half is being filled or awaited, buffer position.
  logic        m_run = 1'b0;
  logic        m_wait = 1'b0;
  int          m_half = 0;
  int          m_ptr = 0;
  logic [1:0]  m_hf = 2'b00;
  logic [31:0] m_ww = 32'd0;
  logic [31:0] m_stall = 32'd0;
  logic        m_en = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [31:0] m_din = 32'd0;

  always @(posedge clk or negedge rst_n) begin : model
    logic        run_n, wait_n, en_n;
    int          half_n, ptr_n;
    logic [1:0]  hf_n;
    logic [31:0] ww_n, st_n, din_n;
    logic [15:0] addr_n;
    if (!rst_n) begin
      m_run <= 1'b0; m_wait <= 1'b0; m_half <= 0; m_ptr <= 0; m_hf <= 2'b00;
      m_ww <= 32'd0; m_stall <= 32'd0; m_en <= 1'b0; m_addr <= 16'd0; m_din <= 32'd0;
    end else begin
      run_n = m_run; wait_n = m_wait; half_n = m_half; ptr_n = m_ptr;
      hf_n = m_hf & ~half_ack; ww_n = m_ww; st_n = m_stall;
      en_n = 1'b0; addr_n = m_addr; din_n = m_din;
      if (!m_run) begin
        if (enable) begin
          run_n = 1'b1; wait_n = 1'b0; half_n = 0; ptr_n = 0;
          hf_n = 2'b00; ww_n = 32'd0; st_n = 32'd0;
        end
      end else if (!enable) begin
        run_n = 1'b0;
      end else if (m_wait) begin
        if (s_valid && m_stall != 32'hFFFF_FFFF) st_n = m_stall + 32'd1;
        if (!m_hf[m_half]) wait_n = 1'b0;
      end else if (s_valid) begin
        en_n   = 1'b1;
        addr_n = 16'(m_ptr * 4);
        din_n  = s_data;
        ww_n   = m_ww + 32'd1;
        ptr_n  = (m_ptr + 1) % DEPTH;
        if ((m_ptr + 1) % HALF == 0) begin
          hf_n[m_half] = 1'b1;
          half_n = 1 - m_half;
          wait_n = m_hf[1 - m_half];
        end
      end
      m_run <= run_n; m_wait <= wait_n; m_half <= half_n; m_ptr <= ptr_n; m_hf <= hf_n;
      m_ww <= ww_n; m_stall <= st_n; m_en <= en_n; m_addr <= addr_n; m_din <= din_n;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("s_ready",       {31'd0, s_ready}, {31'd0, enable && m_run && !m_wait});
      chk("half_full",     {30'd0, half_full}, {30'd0, m_hf});
      chk("bram_en",       {31'd0, bram_en}, {31'd0, m_en});
      chk("bram_we",       {28'd0, bram_we}, {28'd0, {4{m_en}}});
      chk("bram_addr",     {16'd0, bram_addr}, {16'd0, m_addr});
      chk("bram_din",      bram_din, m_din);
      chk("words_written", words_written, m_ww);
      chk("stall_cycles",  stall_cycles, m_stall);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    cyc(2);
    chk_on = 1'b1;
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_en", {31'd0, bram_en}, 32'd0);
    chk("rst_addr", {16'd0, bram_addr}, 32'd0);
    chk("rst_ww", words_written, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    enable = 1'b1;
    cyc();
    chk("start_ready", {31'd0, s_ready}, 32'd1);

    // First half: 0x100..0x107.
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + 32'(i);
      cyc();
    end
    chk("h0_full", {30'd0, half_full}, 32'd1);
    chk("h0_addr", {16'd0, bram_addr}, 32'h1C);
    chk("h0_din", bram_din, 32'h107);
    chk("h0_ww", words_written, 32'd8);
    chk("h0_ready", {31'd0, s_ready}, 32'd1);

    // Second half with no ack, then stall five cycles.
    for (int i = 8; i < 16; i++) begin
      s_data = 32'h100 + 32'(i);
      cyc();
    end
    chk("h1_full", {30'd0, half_full}, 32'd3);
    chk("h1_ready", {31'd0, s_ready}, 32'd0);
    chk("h1_addr", {16'd0, bram_addr}, 32'h3C);
    s_data = 32'h110;
    cyc(5);
    s_valid = 1'b0;
    chk("stall5", stall_cycles, 32'd5);

    // Release half 0: ready two cycles after the pulse, write wraps to 0.
    half_ack = 2'b01;
    cyc();
    half_ack = 2'b00;
    chk("ack_full", {30'd0, half_full}, 32'd2);
    chk("ack_ready1", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("ack_ready2", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1; s_data = 32'h200;
    cyc();
    s_valid = 1'b0;
    chk("wrap_addr", {16'd0, bram_addr}, 32'h0);
    chk("wrap_din", bram_din, 32'h200);
    chk("wrap_ww", words_written, 32'd17);

    // Release half 1, then ack it again while already clear.
    half_ack = 2'b10;
    cyc();
    cyc();
    half_ack = 2'b00;
    chk("ack1_full", {30'd0, half_full}, 32'd0);

    for (int i = 1; i < 8; i++) begin
      s_valid = 1'b1; s_data = 32'h200 + 32'(i);
      cyc();
    end
    chk("h0b_full", {30'd0, half_full}, 32'd1);
    chk("h0b_ww", words_written, 32'd24);

    // Ack on the same edge half 1 completes: the set wins.
    for (int i = 8; i < 16; i++) begin
      s_data = 32'h200 + 32'(i);
      if (i == 15) half_ack = 2'b10;
      cyc();
    end
    half_ack = 2'b00;
    s_valid = 1'b0;
    chk("setwins_full", {30'd0, half_full}, 32'd3);
    chk("setwins_ww", words_written, 32'd32);

    half_ack = 2'b01;
    cyc();
    half_ack = 2'b00;
    cyc();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h300 + 32'(i);
      cyc();
    end

    // Drop enable with data offered: refused, IDLE, counters held.
    enable = 1'b0; s_data = 32'h303;
    #1;
    chk("dis_ready", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("dis_en", {31'd0, bram_en}, 32'd0);
    chk("dis_ww", words_written, 32'd35);
    chk("dis_full", {30'd0, half_full}, 32'd2);
    s_valid = 1'b0;
    cyc();

    // Re-enable: everything restarts from zero.
    enable = 1'b1;
    cyc();
    chk("re_ww", words_written, 32'd0);
    chk("re_full", {30'd0, half_full}, 32'd0);
    s_valid = 1'b1; s_data = 32'h400;
    cyc();
    chk("re_addr", {16'd0, bram_addr}, 32'h0);
    chk("re_din", bram_din, 32'h400);
    chk("re_ww1", words_written, 32'd1);
    s_data = 32'h401;
    cyc();
    s_data = 32'h402;
    cyc();

    // Asynchronous reset between edges with a transfer pending.
    s_data = 32'h403;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, bram_en}, 32'd0);
    chk("arst_addr", {16'd0, bram_addr}, 32'd0);
    chk("arst_din", bram_din, 32'd0);
    chk("arst_ww", words_written, 32'd0);
    chk("arst_ready", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("arst_nowrite", {31'd0, bram_en}, 32'd0);
    s_valid = 1'b0; enable = 1'b0;
    rst_n = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
